// File: rtl/scv_cart_pkg.sv
// Shared types and helpers for the cartridge memory: loader FSM states,
// checksum width and the image-size computation.
package scv_cart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_LOAD   = 2'd2,
    ST_COMMIT = 2'd3
  } ld_state_e;

  localparam int CKSUM_W = 32;

  // Smallest n with 2^n > max_addr, floored at min_log2.
  function automatic logic [4:0] size_from_max(input logic [31:0] max_addr,
                                               input logic [4:0]  min_log2);
    logic [32:0] span;
    logic [4:0]  n;
    span = {1'b0, max_addr} + 33'd1;
    n    = 5'd0;
    for (int i = 0; i < 31; i++) begin
      if ((33'd1 << i) < span) n = 5'(i + 1);
    end
    return (n < min_log2) ? min_log2 : n;
  endfunction

endpackage

// File: rtl/cart_cksum.sv
// Loader accumulator: running byte sum, highest address and any-byte flag,
// plus the committed CKSUM / SIZE_LOG2 / LOADED registers.
module cart_cksum
  import scv_cart_pkg::*;
#(
  parameter int AW       = 17,
  parameter int MIN_LOG2 = 13
) (
  input  logic               CLK,
  input  logic               RESB,
  input  logic               clr,
  input  logic               acc,
  input  logic               commit,
  input  logic [AW-1:0]      addr,
  input  logic [7:0]         data,
  output logic [CKSUM_W-1:0] cksum,
  output logic [4:0]         size_log2,
  output logic               loaded
);

  logic [CKSUM_W-1:0] sum_p0;
  logic [AW-1:0]      max_p0;
  logic               any_p0;

  // Stage p0: accumulate accepted bytes
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      sum_p0 <= '0;
      max_p0 <= '0;
      any_p0 <= 1'b0;
    end else if (clr) begin
      sum_p0 <= '0;
      max_p0 <= '0;
      any_p0 <= 1'b0;
    end else if (acc) begin
      sum_p0 <= sum_p0 + CKSUM_W'(data);
      if (addr > max_p0) max_p0 <= addr;
      any_p0 <= 1'b1;
    end
  end

  // Stage p1: committed image description
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      cksum     <= '0;
      size_log2 <= '0;
      loaded    <= 1'b0;
    end else if (clr) begin
      loaded    <= 1'b0;
    end else if (commit) begin
      if (any_p0) begin
        cksum     <= sum_p0;
        size_log2 <= size_from_max(32'(max_p0), 5'(MIN_LOG2));
        loaded    <= 1'b1;
      end else begin
        cksum     <= '0;
        size_log2 <= '0;
        loaded    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cart_mem.sv
// Cartridge image memory with loader FSM and mirrored registered read port.
// Optional CART_SRAM_EN adds a CPU write port (WRB, DI) for battery-RAM style use.
module cart_mem
  import scv_cart_pkg::*;
#(
  parameter int AW       = 17,
  parameter int MIN_LOG2 = 13
) (
  input  logic               CLK,
  input  logic               RESB,
  input  logic               INIT_SEL,
  input  logic [AW-1:0]      INIT_ADDR,
  input  logic [7:0]         INIT_DATA,
  input  logic               INIT_VALID,
  output logic               INIT_READY,
  output logic [4:0]         SIZE_LOG2,
  output logic [CKSUM_W-1:0] CKSUM,
  output logic               LOADED,
  input  logic [AW-1:0]      A,
  input  logic               CSB,
`ifdef CART_SRAM_EN
  input  logic               WRB,
  input  logic [7:0]         DI,
`endif
  output logic [7:0]         DB
);

  ld_state_e     state_p0, state_nx;
  logic          sel_q;
  logic          acc;
  logic          idle_rd;
  logic          sram_wr;
  logic [AW-1:0] rd_mask;
  logic [AW-1:0] rd_addr;
  logic [7:0]    db_p1;
  logic [7:0]    mem [0:(1<<AW)-1];

  // sel_q resets high so a select already asserted at reset release is ignored
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      state_p0 <= ST_IDLE;
      sel_q    <= 1'b1;
    end else begin
      state_p0 <= state_nx;
      sel_q    <= INIT_SEL;
    end
  end

  always_comb begin
    state_nx = state_p0;
    case (state_p0)
      ST_IDLE:   if (INIT_SEL && !sel_q) state_nx = ST_CLEAR;
      ST_CLEAR:  state_nx = ST_LOAD;
      ST_LOAD:   if (!INIT_SEL) state_nx = ST_COMMIT;
      ST_COMMIT: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  assign INIT_READY = (state_p0 == ST_LOAD) && INIT_SEL;
  assign acc        = INIT_VALID && INIT_READY;

  cart_cksum #(
    .AW       (AW),
    .MIN_LOG2 (MIN_LOG2)
  ) u_cksum (
    .CLK       (CLK),
    .RESB      (RESB),
    .clr       (state_p0 == ST_CLEAR),
    .acc       (acc),
    .commit    (state_p0 == ST_COMMIT),
    .addr      (INIT_ADDR),
    .data      (INIT_DATA),
    .cksum     (CKSUM),
    .size_log2 (SIZE_LOG2),
    .loaded    (LOADED)
  );

  // Small images mirror across the whole CPU window
  always_comb begin
    rd_mask = '0;
    for (int i = 0; i < AW; i++) rd_mask[i] = (i < int'(SIZE_LOG2));
  end

  assign rd_addr = A & rd_mask;
  assign idle_rd = LOADED && (state_p0 == ST_IDLE);

`ifdef CART_SRAM_EN
  assign sram_wr = !CSB && !WRB && idle_rd;

  always_ff @(posedge CLK) begin
    if (acc)          mem[INIT_ADDR] <= INIT_DATA;
    else if (sram_wr) mem[rd_addr]   <= DI;
  end
`else
  assign sram_wr = 1'b0;

  always_ff @(posedge CLK) begin
    if (acc) mem[INIT_ADDR] <= INIT_DATA;
  end
`endif

  // Stage p1: registered read data
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      db_p1 <= 8'hFF;
    end else if (!CSB) begin
      if (!idle_rd)     db_p1 <= 8'hFF;
      else if (!sram_wr) db_p1 <= mem[rd_addr];
    end
  end

  assign DB = db_p1;

endmodule

// File: tb/tb_cart_mem.sv
// Directed bench for cart_mem with an image-level model and per-cycle output checks.
// Define CART_SRAM_EN to also exercise the CPU write port.
module tb_cart_mem;

  localparam int AW       = 17;
  localparam int MIN_LOG2 = 13;

  logic          CLK = 1'b0;
  logic          RESB = 1'b0;
  logic          INIT_SEL = 1'b0;
  logic [AW-1:0] INIT_ADDR = '0;
  logic [7:0]    INIT_DATA = '0;
  logic          INIT_VALID = 1'b0;
  logic          INIT_READY;
  logic [4:0]    SIZE_LOG2;
  logic [31:0]   CKSUM;
  logic          LOADED;
  logic [AW-1:0] A = '0;
  logic          CSB = 1'b1;
  logic [7:0]    DB;
`ifdef CART_SRAM_EN
  logic          WRB = 1'b1;
  logic [7:0]    DI = 8'h00;
`endif

  always #5 CLK = ~CLK;

  cart_mem #(.AW(AW), .MIN_LOG2(MIN_LOG2)) dut (
    .CLK        (CLK),
    .RESB       (RESB),
    .INIT_SEL   (INIT_SEL),
    .INIT_ADDR  (INIT_ADDR),
    .INIT_DATA  (INIT_DATA),
    .INIT_VALID (INIT_VALID),
    .INIT_READY (INIT_READY),
    .SIZE_LOG2  (SIZE_LOG2),
    .CKSUM      (CKSUM),
    .LOADED     (LOADED),
    .A          (A),
    .CSB        (CSB),
`ifdef CART_SRAM_EN
    .WRB        (WRB),
    .DI         (DI),
`endif
    .DB         (DB)
  );

  int vectors = 0;
  int miscompares = 0;

  // Image model: bytes the loader (or CPU) has written, plus session accumulators
  logic [7:0]  m_mem [int];
  logic [31:0] m_sum;
  int          m_max;
  bit          m_any;

  // Expected outputs, held until a stimulus step changes them
  logic        exp_ready  = 1'b0;
  logic        exp_loaded = 1'b0;
  logic [4:0]  exp_size   = 5'd0;
  logic [31:0] exp_cksum  = 32'd0;
  logic [7:0]  exp_db     = 8'hFF;
  bit          exp_db_known = 1'b1;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    cmp("INIT_READY", 32'(INIT_READY), 32'(exp_ready));
    cmp("LOADED",     32'(LOADED),     32'(exp_loaded));
    cmp("SIZE_LOG2",  32'(SIZE_LOG2),  32'(exp_size));
    cmp("CKSUM",      CKSUM,           exp_cksum);
    if (exp_db_known) cmp("DB", 32'(DB), 32'(exp_db));
  end

  function automatic int model_size();
    int s;
    if (!m_any) return 0;
    s = MIN_LOG2;
    while ((1 << s) < m_max + 1) s++;
    return s;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_session();
    INIT_SEL = 1'b1;
    tick();
    tick();
    exp_loaded = 1'b0;
    exp_ready  = 1'b1;
    m_sum = 32'd0;
    m_max = 0;
    m_any = 1'b0;
  endtask

  task automatic put_byte(input int addr, input logic [7:0] data);
    INIT_VALID = 1'b1;
    INIT_ADDR  = AW'(addr);
    INIT_DATA  = data;
    tick();
    m_mem[addr] = data;
    m_sum = m_sum + {24'd0, data};
    if (addr > m_max) m_max = addr;
    m_any = 1'b1;
  endtask

  task automatic end_session(input bit vld_on_drop, input int addr, input logic [7:0] data);
    INIT_VALID = vld_on_drop;
    INIT_ADDR  = AW'(addr);
    INIT_DATA  = data;
    INIT_SEL   = 1'b0;
    exp_ready  = 1'b0;
    tick();
    INIT_VALID = 1'b0;
    tick();
    exp_loaded = m_any;
    exp_size   = 5'(model_size());
    exp_cksum  = m_any ? m_sum : 32'd0;
  endtask

  task automatic rd(input int addr);
    int ma;
    A   = AW'(addr);
    CSB = 1'b0;
    tick();
    CSB = 1'b1;
    exp_db_known = 1'b1;
    if (!exp_loaded) begin
      exp_db = 8'hFF;
    end else begin
      ma = addr & ((1 << exp_size) - 1);
      if (m_mem.exists(ma)) exp_db = m_mem[ma];
      else exp_db_known = 1'b0;
    end
  endtask

  initial begin
    // Reset
    tick(); tick(); tick();
    cmp("reset_DB", 32'(DB), 32'hFF);
    cmp("reset_LOADED", 32'(LOADED), 32'd0);
    RESB = 1'b1;
    tick();

    // 8 KiB of 0x01
    start_session();
    for (int i = 0; i < 8192; i++) put_byte(i, 8'h01);
    end_session(1'b0, 0, 8'h00);
    cmp("8k_size", 32'(SIZE_LOG2), 32'd13);
    cmp("8k_cksum", CKSUM, 32'h2000);
    cmp("8k_loaded", 32'(LOADED), 32'd1);
    rd(5);
    rd(32'h12005);
    cmp("8k_mirror", 32'(DB), 32'h01);

    // Empty session: nothing committed, reads float high
    start_session();
    A = '0; CSB = 1'b0;
    tick();
    CSB = 1'b1; exp_db = 8'hFF; exp_db_known = 1'b1;
    end_session(1'b0, 0, 8'h00);
    cmp("empty_size", 32'(SIZE_LOG2), 32'd0);
    cmp("empty_cksum", CKSUM, 32'd0);
    cmp("empty_loaded", 32'(LOADED), 32'd0);
    rd(32'h10);
    cmp("empty_read", 32'(DB), 32'hFF);

    // 24 KiB image, byte offered as select drops must be ignored
    start_session();
    for (int i = 0; i < 32'h6000; i++) put_byte(i, 8'(i) ^ 8'h5A);
    end_session(1'b1, 32'h9000, 8'hEE);
    cmp("24k_size", 32'(SIZE_LOG2), 32'd15);
    cmp("24k_cksum", CKSUM, 32'h2FD000);
    rd(32'h8003);
    cmp("24k_mirror_8003", 32'(DB), 32'h59);
    rd(32'h15A5A);

    // Reset mid-load with select held: abandoned, then wait for select low
    start_session();
    for (int i = 0; i < 100; i++) put_byte(32'h100 + i, 8'h33);
    INIT_VALID = 1'b0;
    RESB = 1'b0;
    exp_ready = 1'b0; exp_loaded = 1'b0; exp_size = 5'd0; exp_cksum = 32'd0;
    exp_db = 8'hFF; exp_db_known = 1'b1;
    tick(); tick();
    RESB = 1'b1;
    tick(); tick(); tick();
    cmp("post_reset_ready", 32'(INIT_READY), 32'd0);
    cmp("post_reset_loaded", 32'(LOADED), 32'd0);
    INIT_SEL = 1'b0;
    tick();
    start_session();
    for (int i = 0; i < 8192; i++) put_byte(i, 8'(i));
    end_session(1'b0, 0, 8'h00);
    cmp("reload_size", 32'(SIZE_LOG2), 32'd13);
    cmp("reload_cksum", CKSUM, 32'hFF000);
    rd(32'h2010);
    cmp("reload_mirror", 32'(DB), 32'h10);

`ifdef CART_SRAM_EN
    A = AW'(32'h0010); DI = 8'hA5; WRB = 1'b0; CSB = 1'b0;
    tick();
    CSB = 1'b1; WRB = 1'b1;
    m_mem[32'h10] = 8'hA5;
    rd(32'h2010);
    cmp("sram_write", 32'(DB), 32'hA5);
`endif

    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cart_mem.md
CART_MEM -- requirements
Module: cart_mem

Interface
REQ-001 SHALL have parameter AW, default 17, meaning cartridge address width in bits (max image 2^AW bytes).
REQ-002 SHALL have parameter MIN_LOG2, default 13, meaning smallest reportable image size, as log2 bytes.
REQ-003 SHALL have port CLK, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port RESB, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port INIT_SEL, input, 1, loader session active.
REQ-006 SHALL have ports INIT_ADDR (input, AW, load byte address) and INIT_DATA (input, 8, load byte).
REQ-007 SHALL have ports INIT_VALID (input, 1, byte offered) and INIT_READY (output, 1, byte accepted when VALID&READY).
REQ-008 SHALL have ports SIZE_LOG2 (output, 5, committed image size log2) and CKSUM (output, 32, committed byte sum).
REQ-009 SHALL have port LOADED, output, 1, a committed image is present.
REQ-010 SHALL have ports A (input, AW, CPU address), CSB (input, 1, active-low select) and DB (output, 8, read data).

Function
REQ-011 SHALL implement loader FSM states IDLE, CLEAR, LOAD, COMMIT.
REQ-012 IDLE->CLEAR on INIT_SEL rising edge; CLEAR lasts exactly 1 cycle; zeroes the running sum, the max-address tracker and the any-byte flag; drops LOADED to 0; then goes to LOAD.
REQ-013 INIT_READY SHALL be 1 only in LOAD with INIT_SEL=1, and 0 in every other state.
REQ-014 In LOAD, each VALID&READY cycle SHALL write INIT_DATA to mem[INIT_ADDR], add zero-extended INIT_DATA to the 32-bit running sum (mod 2^32), update the max address seen, and set the any-byte flag.
REQ-015 LOAD->COMMIT on INIT_SEL=0; a VALID in that cycle SHALL NOT be accepted (READY already 0).
REQ-016 COMMIT lasts 1 cycle: CKSUM <= running sum; SIZE_LOG2 <= max(MIN_LOG2, ceil-log2(maxaddr+1)); LOADED <= 1; then returns to IDLE.
REQ-017 If the any-byte flag is 0 at COMMIT, SIZE_LOG2 SHALL be 0, CKSUM 0 and LOADED 0.
REQ-018 A new INIT_SEL rising edge while in IDLE after a commit SHALL restart at CLEAR; committed outputs SHALL hold until the next COMMIT.
REQ-019 Read path: DB SHALL be registered with 1-cycle latency: DB <= mem[A & (2^SIZE_LOG2 - 1)] when CSB=0, LOADED=1 and the FSM is in IDLE, so images smaller than 2^AW mirror across the address space.
REQ-020 DB SHALL be loaded with 8'hFF when CSB=0 and either LOADED=0 or the FSM is not in IDLE.
REQ-021 DB SHALL hold its previous value when CSB=1.
REQ-022 Non-power-of-two images SHALL round the size up; bytes never written read as undefined memory contents.

Reset
REQ-023 On RESB=0: FSM to IDLE; INIT_READY=0, LOADED=0, SIZE_LOG2=0, CKSUM=0, DB=8'hFF; internal accumulators cleared.
REQ-024 Reset asserted mid-load SHALL abandon the session with no commit; memory contents are not cleared.
REQ-025 After reset release with INIT_SEL already 1, the FSM SHALL wait for INIT_SEL=0 before a rising edge starts a session.

Configuration
REQ-026 Macro CART_SRAM_EN SHALL add ports WRB (input, 1, active-low write strobe) and DI (input, 8, write data).
REQ-027 With CART_SRAM_EN, CSB=0 & WRB=0 & LOADED=1 & FSM in IDLE SHALL write DI to the mirrored address; DB that cycle SHALL hold its previous value.
REQ-028 Without CART_SRAM_EN, the WRB/DI ports SHALL be absent and the memory SHALL be writable only by the loader.

Structure
REQ-029 Package scv_cart_pkg SHALL hold the loader FSM state enum, the CKSUM_W=32 constant and the size-from-max-address function.
REQ-030 The sum / max-address / size accumulator SHALL be sub-module cart_cksum; memory, FSM and read path SHALL reside in cart_mem.

Verification
REQ-031 Load 8192 bytes at addresses 0..0x1FFF, each byte 0x01 -> SIZE_LOG2=13, CKSUM=0x2000, LOADED=1.
REQ-032 Load addresses 0..0x5FFF -> SIZE_LOG2=15; after commit, A=0x8003 returns mem[0x0003] one cycle later.
REQ-033 Start a session, then drop INIT_SEL with no VALID -> SIZE_LOG2=0, CKSUM=0, LOADED=0; a read with CSB=0 returns 0xFF.
REQ-034 Drive INIT_VALID in the same cycle INIT_SEL falls -> that byte is neither written nor summed.
REQ-035 Assert RESB=0 mid-load after 100 bytes -> all outputs return to reset values and no commit occurs; a subsequent full load commits the correct values.
REQ-036 With CART_SRAM_EN: write 0xA5 at 0x0010 via WRB -> the next read of 0x2010 (8K image) returns 0xA5.
